// File: rtl/seq_counter_ctrl_if.sv
// Control/status bundle for the skip-state sequence counter controller.
interface seq_counter_ctrl_if #(
    parameter int WIDTH = 3
) ();
    logic                  start;
    logic                  stop;
    logic                  step;
    logic                  oneshot;
    logic                  cfg_we;
    logic [2**WIDTH-1:0]   cfg_skip;
    logic [WIDTH-1:0]      count;
    logic                  busy;
    logic                  paused;
    logic                  done;
    logic                  tc;
    logic                  cfg_err;

    modport master (
        output start, stop, step, oneshot, cfg_we, cfg_skip,
        input  count, busy, paused, done, tc, cfg_err
    );

    modport slave (
        input  start, stop, step, oneshot, cfg_we, cfg_skip,
        output count, busy, paused, done, tc, cfg_err
    );
endinterface

// File: rtl/seq_counter_ctrl.sv
// Skip-state binary sequence counter with start/stop/step sequencing
// and a runtime-programmable skip mask (bit i = 1 skips state i).
module seq_counter_ctrl #(
    parameter int                  WIDTH        = 3,
    parameter logic [2**WIDTH-1:0] DEFAULT_SKIP = 8'b1000_1000
) (
    input  logic          clk,
    input  logic          reset,
    seq_counter_ctrl_if.slave bus
);
    localparam int N = 2**WIDTH;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [N-1:0]     mask_q, mask_d;
    logic             tc_q, tc_d;
    logic             err_q, err_d;
    logic             busy_q, paused_q, done_q;

    logic             cfg_ok;
    logic [WIDTH-1:0] first_n, last_n, last_c, next_c;

    function automatic logic [WIDTH-1:0] f_first(input logic [N-1:0] m);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--)
            if (!m[i]) r = i[WIDTH-1:0];
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] f_last(input logic [N-1:0] m);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            if (!m[i]) r = i[WIDTH-1:0];
        return r;
    endfunction

    // Scan offsets high to low so the nearest valid successor wins;
    // with a single valid state the search falls back to c itself.
    function automatic logic [WIDTH-1:0] f_next(
        input logic [WIDTH-1:0] c,
        input logic [N-1:0]     m
    );
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] idx;
        r = c;
        for (int i = N - 1; i >= 1; i--) begin
            idx = c + i[WIDTH-1:0];
            if (!m[idx]) r = idx;
        end
        return r;
    endfunction

    always_comb begin
        cfg_ok = bus.cfg_we && !(&bus.cfg_skip) &&
                 (state_q == S_IDLE || state_q == S_DONE);
        mask_d  = cfg_ok ? bus.cfg_skip : mask_q;
        first_n = f_first(mask_d);
        last_n  = f_last(mask_d);
        last_c  = f_last(mask_q);
        next_c  = f_next(count_q, mask_q);

        state_d = state_q;
        count_d = cfg_ok ? first_n : count_q;
        tc_d    = 1'b0;
        err_d   = bus.cfg_we && !cfg_ok;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (!bus.stop && bus.start) begin
                    state_d = S_RUN;
                    count_d = first_n;
                    tc_d    = (first_n == last_n);
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    state_d = S_PAUSED;
                end else if (bus.oneshot && count_q == last_c) begin
                    state_d = S_DONE;
                end else begin
                    count_d = next_c;
                    tc_d    = (next_c == last_c);
                end
            end
            S_PAUSED: begin
                if (bus.stop) begin
                    state_d = S_PAUSED;
                end else if (bus.start) begin
                    state_d = S_RUN;
                end else if (bus.step) begin
                    count_d = next_c;
                    tc_d    = (next_c == last_c);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            mask_q   <= DEFAULT_SKIP;
            tc_q     <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            paused_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mask_q   <= mask_d;
            tc_q     <= tc_d;
            err_q    <= err_d;
            busy_q   <= (state_d == S_RUN);
            paused_q <= (state_d == S_PAUSED);
            done_q   <= (state_d == S_DONE);
        end
    end

    assign bus.count   = count_q;
    assign bus.busy    = busy_q;
    assign bus.paused  = paused_q;
    assign bus.done    = done_q;
    assign bus.tc      = tc_q;
    assign bus.cfg_err = err_q;
endmodule

// File: tb/tb_seq_counter_ctrl.sv
// Directed-vector bench for seq_counter_ctrl with a queue scoreboard
// drained by an independent monitor on the falling edge.
module tb_seq_counter_ctrl;
    logic clk;
    logic reset;

    seq_counter_ctrl_if #(.WIDTH(3)) bus ();

    seq_counter_ctrl #(
        .WIDTH(3),
        .DEFAULT_SKIP(8'b1000_1000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    // {count[2:0], busy, paused, done, tc, cfg_err}
    logic [7:0] exp_q [$];
    string      name_q [$];
    int         n_chk;
    int         n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [7:0] e;
        logic [7:0] a;
        string      n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {bus.count, bus.busy, bus.paused, bus.done,
                 bus.tc, bus.cfg_err};
            n_chk++;
            if (a === e)
                n_pass++;
            else
                $display("FAIL %s: got cnt=%0d b=%b p=%b d=%b tc=%b err=%b, want cnt=%0d b=%b p=%b d=%b tc=%b err=%b",
                         n, a[7:5], a[4], a[3], a[2], a[1], a[0],
                         e[7:5], e[4], e[3], e[2], e[1], e[0]);
        end
    end

    // Push the expected post-edge outputs, clock once, clear pulse inputs.
    task automatic tick(input string nm, input logic [2:0] c,
                        input logic b, input logic p, input logic d,
                        input logic t, input logic e);
        exp_q.push_back({c, b, p, d, t, e});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.step   = 1'b0;
        bus.cfg_we = 1'b0;
    endtask

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.step   = 1'b0;
        bus.oneshot = 1'b0;
        bus.cfg_we = 1'b0;
        bus.cfg_skip = 8'h00;
        tick("reset", 0, 0, 0, 0, 0, 0);

        // continuous run, default mask
        bus.start = 1'b1;
        tick("t1_start", 0, 1, 0, 0, 0, 0);
        tick("t1_c1", 1, 1, 0, 0, 0, 0);
        tick("t1_c2", 2, 1, 0, 0, 0, 0);
        tick("t1_c4", 4, 1, 0, 0, 0, 0);
        tick("t1_c5", 5, 1, 0, 0, 0, 0);
        tick("t1_c6_tc", 6, 1, 0, 0, 1, 0);
        tick("t1_wrap0", 0, 1, 0, 0, 0, 0);
        tick("t1_c1b", 1, 1, 0, 0, 0, 0);

        // stop at 4, step, resume
        tick("t2_c2", 2, 1, 0, 0, 0, 0);
        tick("t2_c4", 4, 1, 0, 0, 0, 0);
        bus.stop = 1'b1;
        tick("t2_pause", 4, 0, 1, 0, 0, 0);
        bus.stop = 1'b1;
        tick("t2_hold", 4, 0, 1, 0, 0, 0);
        bus.step = 1'b1;
        tick("t2_step5", 5, 0, 1, 0, 0, 0);
        bus.step = 1'b1;
        tick("t2_step6_tc", 6, 0, 1, 0, 1, 0);
        bus.step = 1'b1;
        tick("t2_step0", 0, 0, 1, 0, 0, 0);
        bus.start = 1'b1;
        tick("t2_resume", 0, 1, 0, 0, 0, 0);
        tick("t2_r1", 1, 1, 0, 0, 0, 0);
        tick("t2_r2", 2, 1, 0, 0, 0, 0);
        reset = 1'b1;
        tick("t2_reset", 0, 0, 0, 0, 0, 0);

        // oneshot
        bus.oneshot = 1'b1;
        bus.start = 1'b1;
        tick("t3_start", 0, 1, 0, 0, 0, 0);
        tick("t3_c1", 1, 1, 0, 0, 0, 0);
        tick("t3_c2", 2, 1, 0, 0, 0, 0);
        tick("t3_c4", 4, 1, 0, 0, 0, 0);
        tick("t3_c5", 5, 1, 0, 0, 0, 0);
        tick("t3_c6_tc", 6, 1, 0, 0, 1, 0);
        tick("t3_done", 6, 0, 0, 1, 0, 0);
        tick("t3_done_hold", 6, 0, 0, 1, 0, 0);
        bus.start = 1'b1;
        tick("t3_restart", 0, 1, 0, 0, 0, 0);
        reset = 1'b1;
        bus.oneshot = 1'b0;
        tick("t3_reset", 0, 0, 0, 0, 0, 0);

        // programmed mask 0101_0101: states 1,3,5,7
        bus.cfg_we = 1'b1;
        bus.cfg_skip = 8'b0101_0101;
        tick("t4_cfg", 1, 0, 0, 0, 0, 0);
        bus.start = 1'b1;
        tick("t4_start", 1, 1, 0, 0, 0, 0);
        tick("t4_c3", 3, 1, 0, 0, 0, 0);
        tick("t4_c5", 5, 1, 0, 0, 0, 0);
        tick("t4_c7_tc", 7, 1, 0, 0, 1, 0);
        tick("t4_wrap1", 1, 1, 0, 0, 0, 0);
        tick("t4_c3b", 3, 1, 0, 0, 0, 0);

        // rejected writes
        bus.cfg_we = 1'b1;
        bus.cfg_skip = 8'h00;
        tick("t5_run_err", 5, 1, 0, 0, 0, 1);
        tick("t5_run_kept", 7, 1, 0, 0, 1, 0);
        bus.stop = 1'b1;
        tick("t5_pause", 7, 0, 1, 0, 0, 0);
        bus.cfg_we = 1'b1;
        tick("t5_pause_err", 7, 0, 1, 0, 0, 1);
        reset = 1'b1;
        tick("t5_reset", 0, 0, 0, 0, 0, 0);
        bus.cfg_we = 1'b1;
        bus.cfg_skip = 8'hFF;
        tick("t5_ff_err", 0, 0, 0, 0, 0, 1);
        bus.start = 1'b1;
        tick("t5_def0", 0, 1, 0, 0, 0, 0);
        tick("t5_def1", 1, 1, 0, 0, 0, 0);
        tick("t5_def2", 2, 1, 0, 0, 0, 0);
        tick("t5_def4", 4, 1, 0, 0, 0, 0);

        // reset mid-run, start+stop in IDLE
        tick("t6_c5", 5, 1, 0, 0, 0, 0);
        reset = 1'b1;
        tick("t6_reset", 0, 0, 0, 0, 0, 0);
        bus.start = 1'b1;
        bus.stop = 1'b1;
        tick("t6_stop_wins", 0, 0, 0, 0, 0, 0);
        tick("t6_idle", 0, 0, 0, 0, 0, 0);

        // single valid state, cfg + start same edge
        bus.cfg_we = 1'b1;
        bus.cfg_skip = 8'hFE;
        bus.start = 1'b1;
        tick("b_single_start", 0, 1, 0, 0, 1, 0);
        tick("b_single_tc1", 0, 1, 0, 0, 1, 0);
        tick("b_single_tc2", 0, 1, 0, 0, 1, 0);
        reset = 1'b1;
        tick("b_reset_clr_tc", 0, 0, 0, 0, 0, 0);

        // cfg + start with nonzero FIRST: states 4..7
        bus.cfg_we = 1'b1;
        bus.cfg_skip = 8'h0F;
        bus.start = 1'b1;
        tick("b_hi_start", 4, 1, 0, 0, 0, 0);
        tick("b_hi_c5", 5, 1, 0, 0, 0, 0);
        tick("b_hi_c6", 6, 1, 0, 0, 0, 0);
        tick("b_hi_c7_tc", 7, 1, 0, 0, 1, 0);
        tick("b_hi_wrap4", 4, 1, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/seq_counter_ctrl.md
Name: seq_counter_ctrl

Overview:
Controller for the skip-state binary sequence counter. It owns a WIDTH-bit count register that advances through the states whose skip-mask bit is 0 and wraps after the highest valid state. It provides start/stop/single-step sequencing, continuous or one-shot operation, a terminal-count pulse, and a runtime-programmable skip mask. With the default mask it reproduces the standard 0,1,2,4,5,6,0 sequence.

Parameters:
WIDTH, 3, counter width in bits; the mask has 2**WIDTH bits.
DEFAULT_SKIP, 8'b1000_1000, reset value of the skip mask; bit i=1 means state i is skipped (default skips 3 and 7).

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous reset, active-high.
start  input  1  level sampled each edge; begins or resumes counting.
stop  input  1  level sampled each edge; pauses counting.
step  input  1  level sampled each edge; advances one state while paused.
oneshot  input  1  1 = stop after the last valid state; 0 = wrap continuously.
cfg_we  input  1  write enable for the skip mask.
cfg_skip  input  2**WIDTH  new skip mask.
count  output  WIDTH  current counter state.
busy  output  1  1 while in RUN.
paused  output  1  1 while in PAUSED.
done  output  1  1 while in DONE.
tc  output  1  one-cycle pulse; count has just been loaded with the last valid state.
cfg_err  output  1  one-cycle pulse; the configuration write was rejected.

Behaviour:
- All outputs are registered.
- Reset values: count=0, state IDLE, busy/paused/done/tc/cfg_err=0, mask=DEFAULT_SKIP.
- FIRST = lowest index with mask bit 0. LAST = highest index with mask bit 0.
- NEXT(c) = first index with mask bit 0, searching c+1, c+2, ... modulo 2**WIDTH.
- FSM states: IDLE, RUN, PAUSED, DONE. Input priority on each edge: reset > stop > start > step.
- IDLE:
  - start: count<=FIRST, go to RUN.
  - Otherwise hold.
- RUN:
  - stop: go to PAUSED, count held.
  - oneshot=1 and count==LAST: go to DONE, count held.
  - Otherwise: count<=NEXT(count), wrapping from LAST to FIRST.
  - start is ignored in RUN.
- PAUSED:
  - start: go to RUN. The first advance happens on the following edge.
  - step with no start: count<=NEXT(count), stay in PAUSED. Step always wraps, regardless of oneshot.
  - stop: hold.
- DONE:
  - start: count<=FIRST, go to RUN.
  - Otherwise hold, with done=1.
- tc: set to 1 for exactly the cycle after any update that loads LAST (start, RUN advance, or step). Otherwise 0.
  - If FIRST==LAST (single valid state), tc pulses on every load.
- Configuration:
  - cfg_we is accepted only in IDLE or DONE. The mask updates on that edge, and count<=0 if state 0 is valid, else FIRST of the new mask.
  - cfg_we in RUN or PAUSED: ignored; cfg_err=1 for one cycle.
  - cfg_skip all ones: rejected in any state; mask unchanged; cfg_err=1 for one cycle.
  - cfg_we together with start in IDLE/DONE: the config applies first, and start then loads FIRST of the new mask on the same edge.
- reset asserted mid-operation: on the next edge everything returns to reset values, including mask=DEFAULT_SKIP. Any pending tc/cfg_err is cleared.
- NEXT and FIRST/LAST are combinational priority searches over the mask. There must be no combinational loop from outputs to inputs.

Test Plan:
1. Reset, default mask, oneshot=0; start for 1 cycle. Expect count 0,1,2,4,5,6,0,1 on successive edges; busy=1; tc high the cycle after count becomes 6.
2. Run as in test 1; assert stop while count=4. Expect count held at 4 and paused=1. Three step pulses give 5, 6 (tc pulse), 0. Then start: one held cycle, then 1, 2.
3. oneshot=1, default mask; start. Expect 0,1,2,4,5,6, then DONE with count held at 6, done=1, tc once. Start again: count=0, busy=1.
4. IDLE; cfg_we with cfg_skip=8'b0101_0101. Expect count=1. Start gives 1,3,5,7,1; tc after count becomes 7.
5. cfg_we during RUN, and cfg_skip=8'hFF in IDLE. Each gives a cfg_err one-cycle pulse; mask and sequence are unchanged.
6. Assert reset while count=5 in RUN, and separately start+stop together in IDLE. Reset gives count=0 and IDLE next edge, with the mask back to the default. Start+stop together: stop wins, state stays IDLE, count=0.
